// File: rtl/apb_rr_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_master_if
// Function : APB completer-side bus bundle shared by apb_rr_master and its
//            completer (master/slave modports).
// Revision : 1.0 - initial release
// ============================================================================
interface apb_rr_master_if #(
    parameter int APB_MAX_ADDRESS_WIDTH = 16,
    parameter int APB_MAX_DATA_WIDTH    = 32
);
    logic                             psel;
    logic                             penable;
    logic                             pwrite;
    logic [APB_MAX_ADDRESS_WIDTH-1:0] paddr;
    logic [APB_MAX_DATA_WIDTH-1:0]    pwdata;
    logic                             pready;
    logic                             pslverr;
    logic [APB_MAX_DATA_WIDTH-1:0]    prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_master
// Function : Round-robin arbiter sharing one APB master port among NUM_REQ
//            requesters. Optional ACCESS timeout: APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_rr_master #(
    parameter int NUM_REQ               = 4,
    parameter int APB_MAX_ADDRESS_WIDTH = 16,
    parameter int APB_MAX_DATA_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  wire logic                                      pclk,
    input  wire logic                                      presetn,
    input  wire logic [NUM_REQ-1:0]                        req,
    input  wire logic [NUM_REQ-1:0]                        req_write,
    input  wire logic [NUM_REQ*APB_MAX_ADDRESS_WIDTH-1:0]  req_addr,
    input  wire logic [NUM_REQ*APB_MAX_DATA_WIDTH-1:0]     req_wdata,
    output logic      [NUM_REQ-1:0]                        done,
    output logic      [APB_MAX_DATA_WIDTH-1:0]             rsp_rdata,
    output logic                                           rsp_slverr,
    output logic                                           timeout_err,
    apb_rr_master_if.master                                apb
);
    localparam int              c_AW   = APB_MAX_ADDRESS_WIDTH;
    localparam int              c_DW   = APB_MAX_DATA_WIDTH;
    localparam int              c_IW   = $clog2(NUM_REQ);
    localparam logic [c_IW:0]   c_N    = (c_IW+1)'(NUM_REQ);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_REQ-1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             state_q;
    logic [c_IW-1:0]    rr_ptr_q;
    logic [c_IW-1:0]    grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [c_DW-1:0]    rsp_rdata_q;
    logic               rsp_slverr_q;
    logic               psel_q;
    logic               penable_q;
    logic               pwrite_q;
    logic [c_AW-1:0]    paddr_q;
    logic [c_DW-1:0]    pwdata_q;

    logic [NUM_REQ-1:0] w_arb_req;
    logic [c_IW:0]      w_idx;
    logic               w_arb_found;
    logic [c_IW-1:0]    w_arb_win;
    logic [c_IW-1:0]    rr_ptr_d;
    logic               w_complete;
    logic               w_launch;
    logic               w_win_write;
    logic [c_AW-1:0]    w_win_addr;
    logic [c_DW-1:0]    w_win_wdata;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("apb_rr_master: parameter out of range");
        end
    endgenerate

    assign w_complete = (state_q == ST_ACCESS) && apb.pready;

    // The requester finishing at this edge sits out this arbitration round
    always_comb begin
        w_arb_req   = req;
        w_idx       = '0;
        w_arb_found = 1'b0;
        w_arb_win   = '0;
        if (w_complete) begin
            w_arb_req[grant_q] = 1'b0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, rr_ptr_q} + (c_IW+1)'(k);
            if (w_idx >= c_N) begin
                w_idx = w_idx - c_N;
            end
            if (!w_arb_found && w_arb_req[w_idx[c_IW-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_win   = w_idx[c_IW-1:0];
            end
        end
    end

    assign rr_ptr_d    = (w_arb_win == c_LAST) ? '0 : w_arb_win + c_IW'(1);
    assign w_launch    = w_arb_found && ((state_q == ST_IDLE) || w_complete);
    assign w_win_write = req_write[w_arb_win];
    assign w_win_addr  = req_addr[w_arb_win*c_AW +: c_AW];
    assign w_win_wdata = w_win_write ? req_wdata[w_arb_win*c_DW +: c_DW] : '0;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int              c_CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    logic [c_CW-1:0] wait_cnt_q;
    logic            timeout_err_q;
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            done_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: ;
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (apb.pready) begin
                        done_q[grant_q] <= 1'b1;
                        rsp_rdata_q     <= pwrite_q ? '0 : apb.prdata;
                        rsp_slverr_q    <= apb.pslverr;
                        penable_q       <= 1'b0;
                        psel_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt_q == c_TO_LAST) begin
                        done_q[grant_q] <= 1'b1;
                        rsp_rdata_q     <= '0;
                        rsp_slverr_q    <= 1'b1;
                        timeout_err_q   <= 1'b1;
                        penable_q       <= 1'b0;
                        psel_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + c_CW'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
            // A new grant overrides the return to IDLE, keeping psel high back-to-back
            if (w_launch) begin
                state_q   <= ST_SETUP;
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                grant_q   <= w_arb_win;
                rr_ptr_q  <= rr_ptr_d;
                pwrite_q  <= w_win_write;
                paddr_q   <= w_win_addr;
                pwdata_q  <= w_win_wdata;
            end
        end
    end

    assign done        = done_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_rr_master
// Function : Directed scenarios plus randomized traffic for apb_rr_master,
//            checked every cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_rr_master;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            pclk      = 1'b0;
    logic            presetn   = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;
    logic            timeout_err;

    apb_rr_master_if #(.APB_MAX_ADDRESS_WIDTH(AW), .APB_MAX_DATA_WIDTH(DW)) apb ();

    apb_rr_master #(
        .NUM_REQ(N), .APB_MAX_ADDRESS_WIDTH(AW),
        .APB_MAX_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .timeout_err(timeout_err), .apb(apb)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: one transfer in flight, round-robin pointer
    bit            m_active, m_acc, m_wr, m_err, m_to;
    int            m_g, m_ptr, m_waits;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [N-1:0]  m_done;

    bit auto_slave = 1'b0, rand_post = 1'b0, scramble = 1'b0, hold_all = 1'b0;
    int done_log[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_acc = 0; m_wr = 0; m_err = 0; m_to = 0;
        m_g = 0; m_ptr = 0; m_waits = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_done = '0;
    endtask

    task automatic m_launch(input logic [N-1:0] mask, input logic [N-1:0] wr,
                            input logic [N*AW-1:0] ad, input logic [N*DW-1:0] dt);
        int g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && mask[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        m_g      = g;
        m_ptr    = (g + 1) % N;
        m_active = 1;
        m_acc    = 0;
        m_wr     = wr[g];
        m_addr   = ad[g*AW +: AW];
        m_wdata  = m_wr ? dt[g*DW +: DW] : '0;
    endtask

    task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]                = 1'b1;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: sample inputs at the edge, advance the model, check outputs #1 later
    task automatic step();
        logic [N-1:0]    e_req, e_wr, mask;
        logic [N*AW-1:0] e_addr;
        logic [N*DW-1:0] e_data;
        logic            e_rdy, e_err, e_rstn;
        logic [DW-1:0]   e_rd;
        @(posedge pclk);
        e_req = req; e_wr = req_write; e_addr = req_addr; e_data = req_wdata;
        e_rdy = apb.pready; e_err = apb.pslverr; e_rd = apb.prdata; e_rstn = presetn;
        #1;
        m_done = '0;
        m_to   = 1'b0;
        if (!e_rstn) begin
            model_reset();
        end else if (m_active && !m_acc) begin
            m_acc   = 1;
            m_waits = 0;
        end else if (m_active) begin
            if (e_rdy) begin
                m_done[m_g] = 1'b1;
                m_rdata     = m_wr ? '0 : e_rd;
                m_err       = e_err;
                m_active    = 0;
                mask        = e_req;
                mask[m_g]   = 1'b0;
                if (mask != '0) m_launch(mask, e_wr, e_addr, e_data);
            end else begin
                m_waits++;
`ifdef APB_MASTER_TIMEOUT_EN
                if (m_waits == TO) begin
                    m_done[m_g] = 1'b1;
                    m_err = 1; m_rdata = '0; m_to = 1; m_active = 0;
                end
`endif
            end
        end else if (e_req != '0) begin
            m_launch(e_req, e_wr, e_addr, e_data);
        end

        check("psel", apb.psel, m_active);
        check("penable", apb.penable, m_active && m_acc);
        check("paddr", apb.paddr, m_addr);
        if (m_active) begin
            check("pwrite", apb.pwrite, m_wr);
            check("pwdata", apb.pwdata, m_wdata);
        end
        check("done", done, m_done);
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_slverr", rsp_slverr, m_err);
        check("timeout_err", timeout_err, m_to);

        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done_log.push_back(i);
                req[i] = hold_all;
            end
        end
        if (scramble && m_active) begin
            req_write[m_g]            = 1'($urandom_range(0, 1));
            req_addr[m_g*AW +: AW]    = AW'($urandom);
            req_wdata[m_g*DW +: DW]   = $urandom;
        end
        if (rand_post) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0)
                    post(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
        if (auto_slave) begin
            apb.pready  = ($urandom_range(0, 2) != 0) || (m_active && m_acc && m_waits >= 3);
            apb.prdata  = $urandom;
            apb.pslverr = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((req != '0 || m_active) && n < 200) begin
            step();
            n++;
        end
        check("drain_idle", (req == '0) && !m_active, 1);
    endtask

    initial begin
        int n_acc;
        int n;
        apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;
        model_reset();
        step(); step();
        presetn = 1'b1;

        // Zero-wait write from requester 1
        apb.pready = 1'b1;
        post(1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        step(); check("zw_cycle1", {apb.psel, apb.penable}, 2'b10);
        step(); check("zw_cycle2", {apb.psel, apb.penable}, 2'b11);
        step(); check("zw_done", done, 4'b0010); check("zw_slverr", rsp_slverr, 0);
        step();

        // Read with three wait states from requester 0
        apb.pready = 1'b0; apb.prdata = 32'h1234_5678;
        post(0, 1'b0, 16'h0004, 32'hFFFF_FFFF);
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (apb.penable) begin
                n_acc++;
                check("rw_paddr_stable", apb.paddr, 16'h0004);
            end
        end
        apb.pready = 1'b1;
        step();
        check("rw_access_cycles", n_acc, 4);
        check("rw_done", done, 4'b0001);
        check("rw_rdata", rsp_rdata, 32'h1234_5678);

        // Error response, then a clean transfer
        apb.pslverr = 1'b1;
        post(2, 1'b1, 16'h0200, 32'hCAFE_0002);
        step(); step(); step();
        check("err_done", done, 4'b0100);
        check("err_slverr", rsp_slverr, 1);
        apb.pslverr = 1'b0; apb.prdata = 32'h0BAD_F00D;
        post(3, 1'b0, 16'h0300, 32'h0);
        step(); step(); step();
        check("err_next_done", done, 4'b1000);
        check("err_next_slverr", rsp_slverr, 0);
        check("err_next_rdata", rsp_rdata, 32'h0BAD_F00D);

        // Round-robin fairness with all requesters held
        for (int i = 0; i < N; i++) post(i, 1'(i % 2), AW'(16'h1000 + i * 16), DW'(32'hA0 + i));
        hold_all = 1'b1;
        done_log.delete();
        n = 0;
        while (done_log.size() < 5 && n < 60) begin
            step();
            n++;
        end
        hold_all = 1'b0;
        check("rr_grant_count", done_log.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
            if (k < done_log.size()) check("rr_grant_order", done_log[k], k % 4);
        drain();

        // Reset in the middle of an ACCESS phase
        apb.pready = 1'b0;
        post(1, 1'b1, 16'h0111, 32'h1111_1111);
        step(); step();
        presetn = 1'b0;
        #1;
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_done", done, 4'b0000);
        model_reset();
        req = '0;
        step(); step();
        presetn = 1'b1; apb.pready = 1'b1;
        post(3, 1'b0, 16'h0333, 32'h0);
        step(); check("rst_first_paddr", apb.paddr, 16'h0333);
        step(); step(); check("rst_first_done", done, 4'b1000);
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        // Completer never responds: abort after TO wait cycles
        apb.pready = 1'b0;
        post(0, 1'b0, 16'h0040, 32'h0);
        n = 0;
        do begin
            step();
            n++;
        end while (done == '0 && n < 40);
        check("to_latency", n, TO + 2);
        check("to_done", done, 4'b0001);
        check("to_err", timeout_err, 1);
        check("to_slverr", rsp_slverr, 1);
        check("to_psel", apb.psel, 0);
        apb.pready = 1'b1;
        step();
`endif

        // Randomized traffic with wait states, errors and changing slices
        auto_slave = 1'b1; rand_post = 1'b1; scramble = 1'b1;
        repeat (600) step();
        rand_post = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin arbiter plus APB master FSM that shares one APB completer port among NUM_REQ local requesters.
- Each requester posts a single read or write and holds it until a one-cycle done pulse.
- The block sequences the APB SETUP/ACCESS phases, honours PREADY wait states, and returns PRDATA/PSLVERR to the granted requester.
- It sits between bus-master agents (DMA, CPU bridge, test sequencer) and the APB interface signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- APB_MAX_ADDRESS_WIDTH, 16, PADDR width
- APB_MAX_DATA_WIDTH, 32, PWDATA/PRDATA width
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_MASTER_TIMEOUT_EN)

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  request per requester; held high until matching done
- req_write  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*APB_MAX_ADDRESS_WIDTH  packed addresses; requester i at slice i
- req_wdata  in  NUM_REQ*APB_MAX_DATA_WIDTH  packed write data
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  APB_MAX_DATA_WIDTH  read data; valid while done is high
- rsp_slverr  out  1  error status; valid while done is high
- timeout_err  out  1  one-cycle pulse on timeout abort
- psel, penable, pwrite  out  1 each  APB control signals
- paddr  out  APB_MAX_ADDRESS_WIDTH  APB address
- pwdata  out  APB_MAX_DATA_WIDTH  APB write data
- pready, pslverr  in  1 each  APB completer response
- prdata  in  APB_MAX_DATA_WIDTH  APB read data

Behaviour:
- Reset (presetn low, asynchronous): state=IDLE; rr_ptr=0; all outputs 0.
  - Reset mid-transfer abandons the transfer immediately. No done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - On any req bit high at a posedge, grant the winner g and latch pwrite, paddr and pwdata from slice g.
  - Go to SETUP: psel=1, penable=0.
  - pwdata=0 when the transfer is a read.
- SETUP: always goes to ACCESS on the next edge (penable=1). psel, pwrite, paddr and pwdata stay stable.
- ACCESS:
  - Stay while pready=0; all APB outputs stay stable.
  - On an edge with pready=1: done[g]<=1, rsp_rdata<=prdata (0 for writes), rsp_slverr<=pslverr, penable<=0.
  - Next state at that edge: if another requester is pending, go to SETUP with psel held 1 (back-to-back, no idle cycle). Otherwise go to IDLE with psel<=0.
- Arbitration: round-robin search starting at rr_ptr; after each grant, rr_ptr = g+1 mod NUM_REQ.
  - At the completion edge, requester g is excluded from arbitration.
  - If g keeps req high during its done cycle, that counts as a new request at the following edge.
- Minimum latency: req seen at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done high in cycle 3 (zero wait states).
- Each additional cycle of pready=0 adds one cycle of latency.
- rsp_rdata and rsp_slverr hold their values after done until the next completion.
- paddr holds its last value while idle.
- Changes on req_* slices of the granted requester during a transfer are ignored.
- A requester never sees two done pulses for one request.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted: done[g]=1, rsp_slverr=1, rsp_rdata=0, timeout_err=1 for one cycle, psel=0 and penable=0, then the FSM returns to IDLE.
- Without the macro: ACCESS waits indefinitely for pready, and timeout_err is tied to 0.

Test Plan:
- Zero-wait write: req[1]=1, write, addr 0x0010, data 0xDEADBEEF, pready=1.
  - Expect psel high in cycle 1, penable high in cycle 2, done[1] in cycle 3, rsp_slverr=0.
- Read with wait states: req[0] read at 0x0004, pready low for 3 ACCESS cycles, prdata=0x12345678.
  - Expect 4 ACCESS cycles with paddr stable, then done[0] and rsp_rdata=0x12345678.
- Round-robin fairness: req=4'b1111 held continuously.
  - Expect grant order 0,1,2,3,0 with back-to-back transfers: psel never drops, and every SETUP cycle has penable=0.
- Error response: pslverr=1 with pready on a write from req[2].
  - Expect done[2] with rsp_slverr=1; next transfer unaffected.
- Mid-transfer reset: assert presetn=0 during ACCESS.
  - Expect psel, penable and done at 0 immediately; no done pulse; after release, req[3] is granted first from rr_ptr=0.
- With APB_MASTER_TIMEOUT_EN: pready held 0.
  - Expect abort after 16 wait cycles, with done, rsp_slverr=1 and timeout_err=1 asserted together.
